// File: rtl/crc_chk_param_if.sv
// Bus between the USB RX controller (master) and a serial CRC checker (slave).
//
// Handshake: serial_in is consumed only on cycles where shift_en=1 and the
// checker is not holding a result; eop is a one-cycle strobe that closes the
// packet. Once result_valid=1 the result fields stay stable until the master
// pulses result_ack for one cycle; clear aborts the packet or result at any time.
interface crc_chk_param_if #(
   parameter int CNT_W = 14
);
   logic             clear;
   logic             serial_in;
   logic             shift_en;
   logic             eop;
   logic             result_ack;
   logic             pass;
   logic             result_valid;
   logic             crc_ok;
   logic             short_err;
   logic [CNT_W-1:0] bit_cnt;
   logic [1:0]       dbg_state;

   // RX controller side
   modport master (
      output clear, serial_in, shift_en, eop, result_ack,
      input  pass, result_valid, crc_ok, short_err, bit_cnt, dbg_state
   );

   // Checker side
   modport slave (
      input  clear, serial_in, shift_en, eop, result_ack,
      output pass, result_valid, crc_ok, short_err, bit_cnt, dbg_state
   );
endinterface

// File: rtl/crc_chk_param.sv
// Serial LSB-first CRC checker with bit counting, short-packet detection and
// a held result/ack handshake. One instance per CRC flavour (token CRC5,
// data CRC16). The FSM state is exported on bus.dbg_state for observation.
module crc_chk_param #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] POLY     = 16'h8005,
   parameter logic [WIDTH-1:0] INIT     = '1,
   parameter logic [WIDTH-1:0] RESIDUE  = 16'h800D,
   parameter int               MIN_BITS = 16,
   parameter int               CNT_W    = 14
) (
   input  logic             clk,
   input  logic             rst,
   crc_chk_param_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      RESULT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BITS);

   state_t           state_q;
   logic [WIDTH-1:0] crc_q;
   logic [WIDTH-1:0] crc_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             valid_q;
   logic             ok_q;
   logic             short_q;

   logic             shift_acc;
   logic             fb;
   logic             len_ok_d;
   logic             res_match_d;

   // Next-state CRC and count for an accepted bit; eop evaluates these
   // post-shift values so a bit arriving with eop is part of the packet.
   always_comb begin
      shift_acc   = bus.shift_en && (state_q != RESULT);
      fb          = crc_q[WIDTH-1] ^ bus.serial_in;
      crc_d       = crc_q;
      cnt_d       = cnt_q;
      if (shift_acc) begin
         crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      len_ok_d    = (cnt_d >= MIN_CNT);
      res_match_d = (crc_d == RESIDUE);
   end

   // Packet FSM with registered result flags; clear and ack both restore INIT.
   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         state_q <= IDLE;
         crc_q   <= INIT;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ok_q    <= 1'b0;
         short_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               crc_q <= crc_d;
               cnt_q <= cnt_d;
               if (bus.eop) begin
                  state_q <= RESULT;
                  valid_q <= 1'b1;
                  ok_q    <= res_match_d && len_ok_d;
                  short_q <= !len_ok_d;
               end else if (shift_acc) begin
                  state_q <= ACCUM;
               end
            end
            RESULT: begin
               // Result held; new bits and eop are dropped until acked.
               if (bus.result_ack) begin
                  state_q <= IDLE;
                  crc_q   <= INIT;
                  cnt_q   <= '0;
                  valid_q <= 1'b0;
                  ok_q    <= 1'b0;
                  short_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               crc_q   <= INIT;
               cnt_q   <= '0;
               valid_q <= 1'b0;
               ok_q    <= 1'b0;
               short_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pass         = (crc_q == RESIDUE);
   assign bus.result_valid = valid_q;
   assign bus.crc_ok       = ok_q;
   assign bus.short_err    = short_q;
   assign bus.bit_cnt      = cnt_q;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_crc_chk_param.sv
// Bench for crc_chk_param: a CRC5 token instance and a CRC16 data instance.
// Expected CRC values come from polynomial long division over the whole
// message (INIT*x^n + M(x)*x^W mod G), not from a bit-serial register.
module tb_crc_chk_param;

   localparam logic [15:0] P16 = 16'h8005;
   localparam logic [15:0] I16 = 16'hFFFF;
   localparam logic [15:0] R16 = 16'h800D;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_pass  = 0;
   int n_total = 0;
   logic [15:0] exp_q[$];

   crc_chk_param_if #(.CNT_W(14)) b16 ();
   crc_chk_param_if #(.CNT_W(14)) b5 ();

   crc_chk_param #(
      .WIDTH(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUE(16'h800D),
      .MIN_BITS(16), .CNT_W(14)
   ) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

   crc_chk_param #(
      .WIDTH(5), .POLY(5'b00101), .INIT(5'h1F), .RESIDUE(5'b01100),
      .MIN_BITS(16), .CNT_W(14)
   ) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

   // clock
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [15:0] ref_crc(input int w, input logic [15:0] poly,
                                           input logic [15:0] init, input logic bits[$]);
      logic [127:0] d;
      logic [127:0] g;
      int n;
      n = bits.size();
      d = '0;
      g = '0;
      for (int i = 0; i < w; i++) d[n + i] = init[i];
      for (int i = 0; i < n; i++) d[w + n - 1 - i] = d[w + n - 1 - i] ^ bits[i];
      for (int i = 0; i < w; i++) g[i] = poly[i];
      g[w] = 1'b1;
      for (int k = 127; k >= w; k--) begin
         if (d[k]) d = d ^ (g << (k - w));
      end
      return d[15:0];
   endfunction

   // {crc_ok, short_err, bit_cnt[13:0]} expected for a CRC16 packet
   function automatic logic [15:0] model_result(input logic bits[$]);
      int n;
      logic ok;
      logic sh;
      logic [13:0] c;
      n  = bits.size();
      sh = (n < 16);
      ok = (ref_crc(16, P16, I16, bits) == R16) && !sh;
      c  = (n > 16383) ? 14'h3FFF : 14'(n);
      return {ok, sh, c};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      b16.clear = 0; b16.serial_in = 0; b16.shift_en = 0; b16.eop = 0; b16.result_ack = 0;
      b5.clear  = 0; b5.serial_in  = 0; b5.shift_en  = 0; b5.eop  = 0; b5.result_ack  = 0;
   endtask

   task automatic send16(input logic b, input logic with_eop);
      b16.serial_in = b;
      b16.shift_en  = 1'b1;
      b16.eop       = with_eop;
      tick();
      b16.serial_in = 1'b0;
      b16.shift_en  = 1'b0;
      b16.eop       = 1'b0;
   endtask

   task automatic eop16();
      b16.eop = 1'b1;
      tick();
      b16.eop = 1'b0;
   endtask

   task automatic ack16();
      b16.result_ack = 1'b1;
      tick();
      b16.result_ack = 1'b0;
   endtask

   task automatic clear16();
      b16.clear = 1'b1;
      tick();
      b16.clear = 1'b0;
   endtask

   task automatic send_bits16(input logic bits[$], input logic eop_on_last, input int max_gap);
      for (int i = 0; i < bits.size(); i++) begin
         repeat ($urandom_range(0, max_gap)) tick();
         send16(bits[i], eop_on_last && (i == bits.size() - 1));
      end
      if (!eop_on_last || bits.size() == 0) eop16();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [17:0] got16;
      logic [17:0] got5;
      got16 = {b16.result_valid, b16.crc_ok, b16.short_err, b16.pass, b16.bit_cnt};
      got5  = {b5.result_valid, b5.crc_ok, b5.short_err, b5.pass, b5.bit_cnt};
      n_total++;
      if (got16 !== 18'h0) $display("FAIL reset16: got %h expected %h", got16, 18'h0);
      else n_pass++;
      n_total++;
      if (got5 !== 18'h0) $display("FAIL reset5: got %h expected %h", got5, 18'h0);
      else n_pass++;
   endtask

   task automatic test_crc5_token();
      logic bits[$];
      logic [4:0] exp_r;
      for (int i = 0; i < 11; i++) bits.push_back(1'b0);
      bits.push_back(0); bits.push_back(1); bits.push_back(0); bits.push_back(0); bits.push_back(0);
      exp_r = ref_crc(5, 16'h0005, 16'h001F, bits) == 16'h000C ? 5'b01100 : 5'b00000;
      foreach (bits[i]) begin
         b5.serial_in = bits[i];
         b5.shift_en  = 1'b1;
         tick();
      end
      b5.shift_en = 1'b0;
      b5.serial_in = 1'b0;
      n_total++;
      if ({b5.pass, b5.bit_cnt} !== {(exp_r == 5'b01100), 14'd16})
         $display("FAIL crc5_pass: got pass=%b cnt=%0d expected pass=1 cnt=16", b5.pass, b5.bit_cnt);
      else n_pass++;
      b5.eop = 1'b1;
      tick();
      b5.eop = 1'b0;
      n_total++;
      if ({b5.result_valid, b5.crc_ok, b5.short_err, b5.bit_cnt} !== {3'b110, 14'd16})
         $display("FAIL crc5_result: got v=%b ok=%b sh=%b cnt=%0d expected v=1 ok=1 sh=0 cnt=16",
                  b5.result_valid, b5.crc_ok, b5.short_err, b5.bit_cnt);
      else n_pass++;
      b5.result_ack = 1'b1;
      tick();
      b5.result_ack = 1'b0;
      n_total++;
      if ({b5.result_valid, b5.bit_cnt} !== 15'h0)
         $display("FAIL crc5_ack: got v=%b cnt=%0d expected 0/0", b5.result_valid, b5.bit_cnt);
      else n_pass++;
   endtask

   task automatic test_crc16_good();
      logic bits[$];
      logic [15:0] exp;
      for (int i = 0; i < 16; i++) bits.push_back(1'b0);
      exp_q.push_back(model_result(bits));
      send_bits16(bits, 1'b1, 0);
      exp = exp_q.pop_front();
      n_total++;
      if ({b16.crc_ok, b16.short_err, b16.bit_cnt} !== exp)
         $display("FAIL t2_model: got %h expected %h", {b16.crc_ok, b16.short_err, b16.bit_cnt}, exp);
      else n_pass++;
      n_total++;
      if ({b16.result_valid, b16.crc_ok, b16.short_err, b16.pass, b16.bit_cnt} !== {4'b1101, 14'd16})
         $display("FAIL t2_const: got v=%b ok=%b sh=%b pass=%b cnt=%0d expected 1/1/0/1/16",
                  b16.result_valid, b16.crc_ok, b16.short_err, b16.pass, b16.bit_cnt);
      else n_pass++;
      ack16();
   endtask

   task automatic test_bad_bit();
      logic bits[$];
      logic [15:0] exp;
      for (int i = 0; i < 16; i++) bits.push_back(i == 5);
      exp_q.push_back(model_result(bits));
      send_bits16(bits, 1'b1, 1);
      exp = exp_q.pop_front();
      repeat (3) tick();
      n_total++;
      if ({b16.result_valid, b16.crc_ok, b16.short_err, b16.bit_cnt} !== {1'b1, exp})
         $display("FAIL t3_held: got %h expected %h",
                  {b16.result_valid, b16.crc_ok, b16.short_err, b16.bit_cnt}, {1'b1, exp});
      else n_pass++;
      n_total++;
      if ({b16.crc_ok, b16.short_err} !== 2'b00)
         $display("FAIL t3_flags: got ok=%b sh=%b expected 0/0", b16.crc_ok, b16.short_err);
      else n_pass++;
      ack16();
      n_total++;
      if ({b16.result_valid, b16.pass, b16.bit_cnt} !== 16'h0)
         $display("FAIL t3_ack: got v=%b pass=%b cnt=%0d expected 0/0/0",
                  b16.result_valid, b16.pass, b16.bit_cnt);
      else n_pass++;
   endtask

   task automatic test_short();
      logic bits[$];
      logic [15:0] exp;
      bits = {1'b1, 1'b0, 1'b1};
      exp_q.push_back(model_result(bits));
      send_bits16(bits, 1'b0, 0);
      exp = exp_q.pop_front();
      n_total++;
      if ({b16.result_valid, b16.crc_ok, b16.short_err, b16.bit_cnt} !== {1'b1, exp})
         $display("FAIL t4_short3: got %h expected %h",
                  {b16.result_valid, b16.crc_ok, b16.short_err, b16.bit_cnt}, {1'b1, exp});
      else n_pass++;
      ack16();
      eop16();
      n_total++;
      if ({b16.result_valid, b16.crc_ok, b16.short_err, b16.bit_cnt} !== {3'b101, 14'd0})
         $display("FAIL t4_empty: got v=%b ok=%b sh=%b cnt=%0d expected 1/0/1/0",
                  b16.result_valid, b16.crc_ok, b16.short_err, b16.bit_cnt);
      else n_pass++;
      ack16();
      // ack outside RESULT does nothing harmful
      ack16();
      n_total++;
      if ({b16.result_valid, b16.bit_cnt} !== 15'h0)
         $display("FAIL t4_stray_ack: got v=%b cnt=%0d expected 0/0", b16.result_valid, b16.bit_cnt);
      else n_pass++;
   endtask

   task automatic test_clear();
      logic bits[$];
      logic [15:0] exp;
      for (int i = 0; i < 8; i++) send16(1'($urandom_range(0, 1)), 1'b0);
      clear16();
      n_total++;
      if ({b16.bit_cnt, b16.pass} !== 15'h0)
         $display("FAIL t5_clear: got cnt=%0d pass=%b expected 0/0", b16.bit_cnt, b16.pass);
      else n_pass++;
      for (int i = 0; i < 16; i++) bits.push_back(1'b0);
      exp_q.push_back(model_result(bits));
      send_bits16(bits, 1'b1, 0);
      exp = exp_q.pop_front();
      n_total++;
      if ({b16.crc_ok, b16.short_err, b16.bit_cnt} !== exp || b16.crc_ok !== 1'b1)
         $display("FAIL t5_after_clear: got %h expected %h",
                  {b16.crc_ok, b16.short_err, b16.bit_cnt}, exp);
      else n_pass++;
      // clear while holding a result discards it
      clear16();
      n_total++;
      if ({b16.result_valid, b16.crc_ok} !== 2'b00)
         $display("FAIL t5_clear_result: got v=%b ok=%b expected 0/0", b16.result_valid, b16.crc_ok);
      else n_pass++;
      // reset while holding a result
      eop16();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_total++;
      if ({b16.result_valid, b16.short_err} !== 2'b00)
         $display("FAIL t5_rst_result: got v=%b sh=%b expected 0/0", b16.result_valid, b16.short_err);
      else n_pass++;
   endtask

   task automatic test_result_hold();
      logic bits[$];
      logic [15:0] exp;
      logic [15:0] pay;
      logic [15:0] r;
      logic exp_pass;
      pay = 16'($urandom_range(0, 65535));
      for (int i = 0; i < 16; i++) bits.push_back(pay[i]);
      r = ref_crc(16, P16, I16, bits);
      for (int i = 15; i >= 0; i--) bits.push_back(~r[i]);
      exp_pass = (ref_crc(16, P16, I16, bits) == R16);
      exp_q.push_back(model_result(bits));
      send_bits16(bits, 1'b1, 0);
      exp = exp_q.pop_front();
      for (int i = 0; i < 4; i++) send16(1'($urandom_range(0, 1)), i == 3);
      n_total++;
      if ({b16.result_valid, b16.pass, b16.crc_ok, b16.short_err, b16.bit_cnt} !== {1'b1, exp_pass, exp})
         $display("FAIL t6_hold: got %h expected %h",
                  {b16.result_valid, b16.pass, b16.crc_ok, b16.short_err, b16.bit_cnt},
                  {1'b1, exp_pass, exp});
      else n_pass++;
      ack16();
      n_total++;
      if ({b16.result_valid, b16.bit_cnt} !== 15'h0)
         $display("FAIL t6_ack: got v=%b cnt=%0d expected 0/0", b16.result_valid, b16.bit_cnt);
      else n_pass++;
      bits = {};
      for (int i = 0; i < 20; i++) bits.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(model_result(bits));
      send_bits16(bits, 1'b0, 1);
      exp = exp_q.pop_front();
      n_total++;
      if ({b16.crc_ok, b16.short_err, b16.bit_cnt} !== exp)
         $display("FAIL t6_next: got %h expected %h", {b16.crc_ok, b16.short_err, b16.bit_cnt}, exp);
      else n_pass++;
      ack16();
   endtask

   task automatic test_random();
      for (int p = 0; p < 24; p++) begin
         logic bits[$];
         logic [15:0] r;
         logic [15:0] exp;
         int kind;
         int len;
         logic eop_last;
         bits = {};
         kind = $urandom_range(0, 2);
         len  = (kind == 0) ? $urandom_range(0, 24) : (kind == 1) ? $urandom_range(0, 40) : $urandom_range(0, 15);
         for (int i = 0; i < len; i++) bits.push_back(1'($urandom_range(0, 1)));
         if (kind == 0) begin
            r = ref_crc(16, P16, I16, bits);
            for (int i = 15; i >= 0; i--) bits.push_back(~r[i]);
         end
         eop_last = (bits.size() > 0) && ($urandom_range(0, 1) == 1);
         exp_q.push_back(model_result(bits));
         send_bits16(bits, eop_last, 2);
         exp = exp_q.pop_front();
         repeat ($urandom_range(0, 3)) tick();
         n_total++;
         if ({b16.result_valid, b16.crc_ok, b16.short_err, b16.bit_cnt} !== {1'b1, exp})
            $display("FAIL rand_pkt%0d: got %h expected %h", p,
                     {b16.result_valid, b16.crc_ok, b16.short_err, b16.bit_cnt}, {1'b1, exp});
         else n_pass++;
         ack16();
      end
   endtask

   task automatic test_saturate();
      b16.serial_in = 1'b0;
      b16.shift_en  = 1'b1;
      repeat (16390) tick();
      b16.shift_en = 1'b0;
      eop16();
      n_total++;
      if ({b16.result_valid, b16.short_err, b16.bit_cnt} !== {2'b10, 14'h3FFF})
         $display("FAIL saturate: got v=%b sh=%b cnt=%0d expected 1/0/16383",
                  b16.result_valid, b16.short_err, b16.bit_cnt);
      else n_pass++;
      ack16();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_all();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_crc5_token();
      test_crc16_good();
      test_bad_bit();
      test_short();
      test_clear();
      test_result_hold();
      test_random();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
